// File: rtl/sram_like_responder.sv
// sram_like_responder
// Responder end of the SRAM-like bus. Each accepted request is issued to an
// external synchronous single-port RAM in the same cycle. The RAM result is
// captured one cycle later by a one-entry pending stage and queued in a small
// response FIFO. Responses return strictly in acceptance order, and at most
// DEPTH transactions are outstanding at any time.
//
// Optional feature: define SRAM_RESP_RAND_DELAY_EN to add LFSR-driven random
// stalls on addr_ok and data_ok. These stalls change only handshake timing;
// data and ordering are unchanged. With the macro undefined the latency is
// fixed at two cycles from accept to data_ok.

module sram_like_responder #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sram_req,
   input  logic              sram_wr,
   input  logic [1:0]        sram_size,
   input  logic [3:0]        sram_wstrb,
   input  logic [31:0]       sram_addr,
   input  logic [31:0]       sram_wdata,
   output logic              sram_addr_ok,
   output logic              sram_data_ok,
   output logic [31:0]       sram_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   // A DEPTH of 1 still needs a one-bit pointer; wrapping is explicit below.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

   logic              accept;
   logic              addr_stall;
   logic              data_stall;
   logic [CNT_W:0]    outstanding;

   logic              pend;
   logic              pend_wr;

   logic [31:0]       fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic              push;
   logic              pop;
   logic [31:0]       push_data;

   logic [ADDR_W-1:0] ram_addr_q;
   logic [31:0]       ram_wdata_q;

   // sram_size and the address bits outside the word index are not decoded.
   logic              unused_bits;
   assign unused_bits = ^{sram_size, sram_addr[31:ADDR_W+2], sram_addr[1:0]};

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef SRAM_RESP_RAND_DELAY_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   // Fibonacci taps 16,14,13,11.
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Free-running stall generator, advances every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end

   assign addr_stall = (lfsr[1:0] == 2'b00);
   assign data_stall = (lfsr[3:2] == 2'b00);
`else
   assign addr_stall = 1'b0;
   assign data_stall = 1'b0;
`endif

   // Anything in the pending stage or in the FIFO counts against the limit,
   // so the FIFO can never overflow.
   assign outstanding = {{CNT_W{1'b0}}, pend} + {1'b0, fifo_count};

   // Gating with reset keeps the bus and the RAM quiet while reset is held,
   // even if the initiator keeps sram_req high.
   assign accept       = sram_req & ~reset & (outstanding < DEPTH_V) & ~addr_stall;
   assign sram_addr_ok = accept;

   assign ram_en    = accept;
   assign ram_we    = (accept & sram_wr) ? sram_wstrb : 4'b0000;
   assign ram_addr  = accept ? sram_addr[ADDR_W+1:2] : ram_addr_q;
   assign ram_wdata = accept ? sram_wdata : ram_wdata_q;

   // Hold the last issued address/data so the RAM pins stay stable when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else if (accept) begin
         ram_addr_q  <= sram_addr[ADDR_W+1:2];
         ram_wdata_q <= sram_wdata;
      end
   end

   // Pending stage: tracks the access issued last cycle, whose RAM data is
   // on ram_rdata now.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend    <= 1'b0;
         pend_wr <= 1'b0;
      end else begin
         pend <= accept;
         if (accept) begin
            pend_wr <= sram_wr;
         end
      end
   end

   assign push      = pend;
   assign push_data = pend_wr ? 32'h0 : ram_rdata;
   assign pop       = sram_data_ok;

   // FIFO pointers and occupancy; a push and a pop together leave the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // FIFO storage: data needs no reset because the count qualifies it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= push_data;
      end
   end

   // The initiator cannot backpressure, so every data_ok pops the head entry.
   assign sram_data_ok = (fifo_count != '0) & ~data_stall;
   assign sram_rdata   = sram_data_ok ? fifo_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder. It attaches a behavioural synchronous RAM,
// predicts every response with a reference memory, and compares the
// responses in order through a scoreboard queue.
module tb_sram_like_responder;

   localparam int ADDR_W = 14;
   localparam int DEPTH  = 2;
   localparam int WORDS  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              sram_req = 1'b0;
   logic              sram_wr = 1'b0;
   logic [1:0]        sram_size = 2'd2;
   logic [3:0]        sram_wstrb = 4'h0;
   logic [31:0]       sram_addr = 32'h0;
   logic [31:0]       sram_wdata = 32'h0;
   logic              sram_addr_ok;
   logic              sram_data_ok;
   logic [31:0]       sram_rdata;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata = 32'h0;

   sram_like_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .sram_req     (sram_req),
      .sram_wr      (sram_wr),
      .sram_size    (sram_size),
      .sram_wstrb   (sram_wstrb),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_addr_ok (sram_addr_ok),
      .sram_data_ok (sram_data_ok),
      .sram_rdata   (sram_rdata),
      .ram_en       (ram_en),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // external synchronous RAM, read data one cycle after ram_en
   logic [31:0] ram_mem [0:WORDS-1];
   always @(posedge clk) begin
      if (ram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
         ram_rdata <= ram_mem[ram_addr];
      end
   end

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } sb_t;

   sb_t               sb[$];
   sb_t               e;
   logic [31:0]       ref_mem [0:WORDS-1];
   logic [ADDR_W-1:0] idx;
   int                n_chk = 0;
   int                n_pass = 0;
   int                acc_cnt = 0;
   int                pop_cnt = 0;
   int                outst = 0;
   int                max_sb = 0;
   logic              addr_stall_seen = 1'b0;
   logic              data_stall_seen = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // monitor: records accepts into the scoreboard and checks every response
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         acc_cnt = 0;
         pop_cnt = 0;
      end else begin
         outst = acc_cnt - pop_cnt;
         if (sram_req && !sram_addr_ok && outst < DEPTH) addr_stall_seen = 1'b1;
         if (sb.size() > 0 && sb[0].cyc <= cyc - 2 && !sram_data_ok) data_stall_seen = 1'b1;
         if (sram_data_ok) begin
            if (sb.size() == 0) begin
               check("spurious_data_ok", {31'b0, sram_data_ok}, 32'h0);
            end else begin
               e = sb.pop_front();
               check("rdata", sram_rdata, e.data);
`ifndef SRAM_RESP_RAND_DELAY_EN
               check("latency", cyc, e.cyc + 2);
`endif
               pop_cnt++;
            end
         end else begin
            check("rdata_idle_zero", sram_rdata, 32'h0);
         end
         if (sram_addr_ok) begin
            idx = sram_addr[ADDR_W+1:2];
            check("ram_en", {31'b0, ram_en}, 32'h1);
            check("ram_addr", {18'b0, ram_addr}, {18'b0, idx});
            check("ram_we", {28'b0, ram_we}, {28'b0, (sram_wr ? sram_wstrb : 4'b0000)});
            check("ram_wdata", ram_wdata, sram_wdata);
            if (sram_wr) begin
               for (int b = 0; b < 4; b++) begin
                  if (sram_wstrb[b]) ref_mem[idx][8*b +: 8] = sram_wdata[8*b +: 8];
               end
               sb.push_back('{data: 32'h0, cyc: cyc});
            end else begin
               sb.push_back('{data: ref_mem[idx], cyc: cyc});
            end
            acc_cnt++;
            if (sb.size() > max_sb) max_sb = sb.size();
         end else begin
            check("ram_idle", {27'b0, ram_en, ram_we}, 32'h0);
         end
      end
   end

   // present one request until accepted; returns the accept cycle
   task automatic send(input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                       input logic [31:0] wdata, output int acc_cyc);
      int n = 0;
      sram_req   = 1'b1;
      sram_wr    = wr;
      sram_wstrb = strb;
      sram_addr  = addr;
      sram_wdata = wdata;
      forever begin
         @(negedge clk);
         if (sram_addr_ok) break;
         n++;
         if (n > 64) begin
            check("accept_timeout", {31'b0, sram_addr_ok}, 32'h1);
            break;
         end
         @(posedge clk);
         #1;
      end
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      sram_req = 1'b0;
   endtask

   task automatic wait_resp(output logic [31:0] d, output int c);
      int n = 0;
      d = 32'hx;
      c = -1;
      forever begin
         @(negedge clk);
         if (sram_data_ok) begin
            d = sram_rdata;
            c = cyc;
            break;
         end
         n++;
         if (n > 32) begin
            check("resp_timeout", {31'b0, sram_data_ok}, 32'h1);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain", sb.size(), 32'h0);
      @(posedge clk);
      #1;
   endtask

   // fallback if the DUT stops making progress
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, n_pass %0d n_chk %0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int          t;
      int          c;
      int          p0;
      logic [31:0] d;
      logic [31:0] a;
      logic [5:0]  pat;

      // reset state, with a request presented during reset
      sram_req  = 1'b1;
      sram_addr = 32'h0000_0040;
      sram_wdata = 32'h1234_5678;
      #3;
      check("rst_addr_ok", {31'b0, sram_addr_ok}, 32'h0);
      check("rst_data_ok", {31'b0, sram_data_ok}, 32'h0);
      check("rst_rdata", sram_rdata, 32'h0);
      check("rst_ram_en", {31'b0, ram_en}, 32'h0);
      check("rst_ram_we", {28'b0, ram_we}, 32'h0);
      check("rst_ram_addr", {18'b0, ram_addr}, 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      sram_req = 1'b0;
      #9;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // single read with upper address bits ignored
      send(1'b1, 4'hF, 32'h0000_0400, 32'hDEAD_BEEF, t);
      drain();
      send(1'b0, 4'h0, 32'h1C00_0400, 32'h0, t);
      wait_resp(d, c);
      check("single_read_data", d, 32'hDEAD_BEEF);
      check("single_read_cycle", c, t + 2);
      drain();

      // byte write then read back
      send(1'b1, 4'hF, 32'h0000_0008, 32'h1122_3344, t);
      drain();
      send(1'b1, 4'b0010, 32'h0000_0008, 32'h0000_AB00, t);
      wait_resp(d, c);
      check("byte_write_resp", d, 32'h0);
      send(1'b0, 4'h0, 32'h0000_0008, 32'h0, t);
      wait_resp(d, c);
      check("byte_merge_read", d, 32'h1122_AB44);
      drain();

      // preload words 0..9, then wrap-around reads
      for (int i = 0; i < 10; i++) send(1'b1, 4'hF, 32'(i * 4), 32'hA500_0000 + 32'(i), t);
      drain();
      p0 = pop_cnt;
      for (int i = 0; i < 10; i++) send(1'b0, 4'h0, 32'(i * 4), 32'h0, t);
      drain();
      check("wrap_resp_count", pop_cnt - p0, 32'd10);

`ifndef SRAM_RESP_RAND_DELAY_EN
      // sustained request with DEPTH=2: accept pattern 1,1,0,1,1,0
      pat = 6'b110110;
      a = 32'h0;
      sram_req = 1'b1;
      sram_wr = 1'b0;
      for (int k = 0; k < 6; k++) begin
         sram_addr = a;
         @(negedge clk);
         check("stall_accept", {31'b0, sram_addr_ok}, {31'b0, pat[5-k]});
         if (sram_addr_ok) a = a + 32'h4;
         @(posedge clk);
         #1;
      end
      sram_req = 1'b0;
      drain();
`endif

      // reset mid-operation with two reads outstanding
      send(1'b0, 4'h0, 32'h0, 32'h0, t);
      send(1'b0, 4'h0, 32'h4, 32'h0, t);
      sram_req   = 1'b1;
      sram_wr    = 1'b1;
      sram_wstrb = 4'hF;
      sram_addr  = 32'h0000_0014;
      sram_wdata = 32'hBAD0_BAD0;
      #1;
      reset = 1'b1;
      #1;
      check("midrst_addr_ok", {31'b0, sram_addr_ok}, 32'h0);
      check("midrst_data_ok", {31'b0, sram_data_ok}, 32'h0);
      check("midrst_rdata", sram_rdata, 32'h0);
      check("midrst_ram_en", {31'b0, ram_en}, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #2;
      sram_req = 1'b0;
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("post_reset_pops", pop_cnt, 32'h0);
      // RAM contents written before reset survive
      send(1'b0, 4'h0, 32'h0000_0014, 32'h0, t);
      wait_resp(d, c);
      check("persist_after_reset", d, 32'hA500_0005);
      drain();

      // random traffic
      for (int i = 0; i < 64; i++) send(1'b1, 4'hF, 32'(i * 4), $urandom, t);
      drain();
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(1'($urandom_range(1)), 4'($urandom_range(15)), 32'($urandom_range(63) * 4),
              $urandom, t);
      end
      drain();
      check("max_outstanding", {31'b0, (max_sb <= DEPTH)}, 32'h1);
`ifdef SRAM_RESP_RAND_DELAY_EN
      check("addr_stall_seen", {31'b0, addr_stall_seen}, 32'h1);
      check("data_stall_seen", {31'b0, data_stall_seen}, 32'h1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

Responder end of the SRAM-like bus (req/wr/size/wstrb/addr/wdata in; addr_ok/data_ok/rdata out). It accepts requests from a pipeline initiator such as the instruction or data fetch port, and performs each access on an external synchronous single-port RAM. It returns responses strictly in order, with a bounded number of outstanding transactions. It serves as the memory model in the SoC-lite bench and as the on-chip RAM front end.

## Interface
- ADDR_W, 14: RAM word-index width; the RAM covers 2^ADDR_W 32-bit words.
- DEPTH, 2: maximum outstanding transactions; power of 2, ≥1.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sram_req  in  1  request valid.
- sram_wr  in  1  1=write, 0=read.
- sram_size  in  2  0:1B 1:2B 2:4B; informational, not decoded.
- sram_wstrb  in  4  byte write strobes, used only when sram_wr=1.
- sram_addr  in  32  byte address; bits [ADDR_W+1:2] index the RAM, other bits ignored.
- sram_wdata  in  32  write data.
- sram_addr_ok  out  1  request accepted this cycle.
- sram_data_ok  out  1  response valid this cycle.
- sram_rdata  out  32  read data, qualified by sram_data_ok.
- ram_en  out  1  RAM access enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM word index.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after a read with ram_en=1.

## Operation
- **Acceptance.** sram_addr_ok = sram_req & (outstanding < DEPTH) & ~addr_stall.
  - The signal is combinational from sram_req and registered state.
  - outstanding = pend + fifo_count.
  - addr_stall = 0 unless the macro in Configuration is defined.
- **RAM issue on accept.** The RAM access is issued in the same cycle as the accept:
  - ram_en=1.
  - ram_addr=sram_addr[ADDR_W+1:2].
  - ram_wdata=sram_wdata.
  - ram_we = sram_wr ? sram_wstrb : 4'b0000.
- **Idle RAM outputs.** When no accept occurs, ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their last driven value.
- **Pending stage.** On an accept, a one-entry pending register is loaded with pend=1 and pend_wr=sram_wr.
  - Next cycle it pushes a response into the response FIFO.
  - The pushed data is ram_rdata for a read and 32'h0 for a write.
- **Response FIFO.** Depth DEPTH, circular, with wrapping read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
- **Response output.**
  - sram_data_ok = (fifo_count≠0) & ~data_stall.
  - sram_rdata = head entry when sram_data_ok is high, else 32'h0.
  - The initiator has no backpressure: each cycle sram_data_ok=1 pops one entry.
- **Ordering.** Responses return strictly in acceptance order. Writes also return a sram_data_ok.
- **Simultaneous events.**
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Accept, pending push and pop can all occur in one cycle.
  - Because outstanding ≤ DEPTH, the FIFO never overflows. No overflow flag.
- **No-accept cases.** A request with outstanding==DEPTH gets no addr_ok. It is not accepted in a later cycle unless sram_req is still high then.

## Timing
- Fixed latency without stalls: accept at cycle T, RAM read at T, pending captured at T+1, sram_data_ok at T+2.
- Back-to-back throughput is 1 request/cycle only if DEPTH ≥ 3. With DEPTH=2, sustained rate is 2 requests per 3 cycles.
- Reset (async, active-high):
  - Outputs: sram_addr_ok, sram_data_ok, ram_en and ram_we follow from the cleared state, so all are 0 during reset. sram_rdata=0. ram_addr=0 and ram_wdata=0.
  - State: pend=0, FIFO pointers and count=0, LFSR=16'hACE1.
- Reset mid-operation: all in-flight responses are discarded and none are returned after reset. RAM writes issued before reset persist.

## Configuration
- SRAM_RESP_RAND_DELAY_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advances every cycle.
  - addr_stall = (lfsr[1:0]==2'b00).
  - data_stall = (lfsr[3:2]==2'b00).
  - Ordering and data are unchanged; only addr_ok/data_ok timing varies.
- SRAM_RESP_RAND_DELAY_EN undefined: addr_stall=data_stall=0, there is no LFSR, and latency is fixed as in Timing.

## Test plan
- **Reset.** Assert reset asynchronously mid-cycle with 2 reads outstanding -> immediate sram_addr_ok=0, sram_data_ok=0, sram_rdata=0, ram_en=0. After release, no stale data_ok appears.
- **Single read.** RAM word 0x100 preloaded with 32'hDEADBEEF; read of sram_addr=0x1C000400 at T -> sram_addr_ok at T, ram_addr=0x100 at T, data_ok with rdata=32'hDEADBEEF at T+2.
- **Byte write then read.** Write wstrb=4'b0010, wdata=32'h0000AB00 to addr 0x8 over word 32'h11223344, then read 0x8 -> ram_we=4'b0010, then rdata=32'h1122AB44. The write's own data_ok has rdata=0.
- **Full stall, DEPTH=2.** sram_req held high with no stalls -> accepts at T, T+1, none at T+2, accept at T+3. data_ok at T+2 and T+3 in order.
- **Wrap-around.** 10 sequential reads of addr 0x0,0x4,...,0x24 -> 10 data_ok returning words 0..9 in order; FIFO pointers wrap ≥4 times with no drop or duplicate.
- **Random delay (macro defined).** 1000 random reads/writes checked against a scoreboard -> all responses in order and correct. At least one addr_ok stall and one data_ok stall observed; outstanding never exceeds DEPTH.
